// File: rtl/matlib_pkg.sv
// Shared math-library types and helpers: requester index type and the
// round-robin "first set bit at or after a pointer" search.
package matlib_pkg;

  localparam int MAX_NREQ = 16;

  typedef logic [$clog2(MAX_NREQ)-1:0] idx_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } rr_pick_t;

  // Scans n candidates starting at ptr, wrapping from n-1 back to 0.
  function automatic rr_pick_t rr_first(input logic [MAX_NREQ-1:0] vld,
                                        input idx_t ptr, input int n);
    rr_pick_t r;
    logic [4:0] j;
    r = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      j = 5'(ptr) + 5'(i);
      if (j >= 5'(n)) j = j - 5'(n);
      if (i < n && !r.found && vld[j[3:0]]) begin
        r.found = 1'b1;
        r.idx   = j[3:0];
      end
    end
    return r;
  endfunction

  function automatic idx_t next_idx(input idx_t k, input int n);
    return (int'(k) == n - 1) ? '0 : idx_t'(int'(k) + 1);
  endfunction

endpackage

// File: rtl/fixedp_if.sv
// Fixed-point multiplier-sharing bus: requester handshakes, shared multiplier
// operands/product and the response channel, plus the number format.
interface fixedp_if #(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 3,
  parameter int NREQ    = 4
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_lock;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0]            req_ready;
  logic [WIDTH-1:0]           mul_a;
  logic [WIDTH-1:0]           mul_b;
  logic [WIDTH-1:0]           mul_p;
  logic [NREQ-1:0]            rsp_valid;
  logic [WIDTH-1:0]           rsp_p;

  modport master (
    output req_valid, req_lock, req_a, req_b, mul_p,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_p
  );

  modport slave (
    input  req_valid, req_lock, req_a, req_b, mul_p,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_p
  );
endinterface

// File: rtl/valid_delay.sv
// Fixed-latency valid delay line; cleared by reset so in-flight flags vanish.
module valid_delay #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] vld_p [DELAY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DELAY; i++) vld_p[i] <= '0;
    end else begin
      vld_p[0] <= din;
      for (int i = 1; i < DELAY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign dout = vld_p[DELAY-1];
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter with bounded lock bursts, sharing one pipelined
// multiplier among NREQ requesters and routing each product back to its owner.
module mul_arbiter
  import matlib_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic     clk,
  input  logic     reset,
  fixedp_if.slave  g
);
  idx_t                ptr, lock_own, gnt_idx;
  logic                lock_vld, gnt_vld, hold;
  logic [7:0]          burst_cnt;
  logic [MAX_NREQ-1:0] vld_w, lck_w, others;
  logic [NREQ-1:0]     gnt_oh, dly_vld;
  rr_pick_t            pick;

  always_comb begin
    vld_w = '0;
    vld_w[NREQ-1:0] = g.req_valid;
    lck_w = '0;
    lck_w[NREQ-1:0] = g.req_lock;
    others = vld_w;
    others[lock_own] = 1'b0;
    pick = rr_first(vld_w, ptr, NREQ);
    // A saturated burst keeps going only when nobody else is waiting.
    hold = lock_vld && vld_w[lock_own] &&
           (burst_cnt < 8'(MAX_BURST) || others == '0);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!reset) begin
      if (hold) begin
        gnt_vld = 1'b1;
        gnt_idx = lock_own;
      end else if (pick.found) begin
        gnt_vld = 1'b1;
        gnt_idx = pick.idx;
      end
    end
    gnt_oh = '0;
    g.mul_a = '0;
    g.mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == idx_t'(i));
      if (gnt_oh[i]) begin
        g.mul_a = g.req_a[i];
        g.mul_b = g.req_b[i];
      end
    end
    g.req_ready = gnt_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      lock_own  <= '0;
      lock_vld  <= 1'b0;
      burst_cnt <= '0;
    end else if (gnt_vld) begin
      ptr      <= next_idx(gnt_idx, NREQ);
      lock_own <= gnt_idx;
      lock_vld <= lck_w[gnt_idx];
      if (lock_vld && gnt_idx == lock_own)
        burst_cnt <= (burst_cnt < 8'(MAX_BURST)) ? burst_cnt + 8'd1 : burst_cnt;
      else
        burst_cnt <= 8'd1;
    end else begin
      lock_vld  <= 1'b0;
      burst_cnt <= '0;
    end
  end

  // Grant -> response boundary: the grant rides alongside the multiplier pipe.
  valid_delay #(.WIDTH(NREQ), .DELAY(g.MUL_LAT)) u_dly (
    .clk   (clk),
    .reset (reset),
    .din   (gnt_oh),
    .dout  (dly_vld)
  );

  assign g.rsp_valid = reset ? '0 : dly_vld;
  assign g.rsp_p     = g.mul_p;
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: two instances (MAX_BURST 4 and 2), directed table,
// hand sequence and randomized stress against a behavioural scoreboard.
module tb_mul_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fixedp_if #(.WIDTH(W), .MUL_LAT(LAT), .NREQ(N)) ga ();
  fixedp_if #(.WIDTH(W), .MUL_LAT(LAT), .NREQ(N)) gb ();

  mul_arbiter #(.NREQ(N), .MAX_BURST(4)) u_a (.clk(clk), .reset(reset), .g(ga));
  mul_arbiter #(.NREQ(N), .MAX_BURST(2)) u_b (.clk(clk), .reset(reset), .g(gb));

  // Shared multipliers: LAT-stage pipes, product truncated to W bits.
  logic [W-1:0] pipe_a [LAT];
  logic [W-1:0] pipe_b [LAT];
  always @(posedge clk) begin
    pipe_a[0] <= W'(ga.mul_a * ga.mul_b);
    pipe_b[0] <= W'(gb.mul_a * gb.mul_b);
    for (int i = 1; i < LAT; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign ga.mul_p = pipe_a[LAT-1];
  assign gb.mul_p = pipe_b[LAT-1];

  typedef struct { int due; int k; logic [W-1:0] p; } rsp_t;
  typedef struct {
    bit rst;
    logic [3:0] va, la, ea, ra, vb, lb, eb, rb;
  } vec_t;

  rsp_t qa[$];
  rsp_t qb[$];
  vec_t tbl[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [N-1:0] vv [2];
  logic [N-1:0] ll [2];
  logic [W-1:0] opa [2][N];
  logic [W-1:0] opb [2][N];
  int last_k [2];
  int run [2];
  bit last_lock [2];
  bit prev_gnt [2];
  int eg [2];
  int wait_c [2][N];
  int max_wait [2];

  function automatic int max_burst(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  // Who should win this cycle, from the grant history kept in the model.
  function automatic int model_grant(input int d);
    logic [N-1:0] v, oth;
    int start;
    v = vv[d];
    if (reset || v == '0) return -1;
    if (prev_gnt[d] && last_lock[d] && v[last_k[d]]) begin
      oth = v;
      oth[last_k[d]] = 1'b0;
      if (run[d] < max_burst(d) || oth == '0) return last_k[d];
    end
    start = (last_k[d] < 0) ? 0 : (last_k[d] + 1) % N;
    for (int i = 0; i < N; i++)
      if (v[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [3:0] va, la, ea, ra, vb, lb, eb, rb);
    vec_t t;
    t.rst = rst; t.va = va; t.la = la; t.ea = ea; t.ra = ra;
    t.vb = vb; t.lb = lb; t.eb = eb; t.rb = rb;
    tbl.push_back(t);
  endtask

  task automatic apply();
    ga.req_valid = vv[0];
    ga.req_lock  = ll[0];
    gb.req_valid = vv[1];
    gb.req_lock  = ll[1];
    for (int k = 0; k < N; k++) begin
      ga.req_a[k] = opa[0][k];
      ga.req_b[k] = opb[0][k];
      gb.req_a[k] = opa[1][k];
      gb.req_b[k] = opb[1][k];
    end
  endtask

  task automatic check_dut(input int d);
    logic [N-1:0] rdy, rv;
    logic [W-1:0] rp, ma, mb;
    int gk;
    bit have;
    rsp_t e;
    if (d == 0) begin
      rdy = ga.req_ready; rv = ga.rsp_valid; rp = ga.rsp_p; ma = ga.mul_a; mb = ga.mul_b;
    end else begin
      rdy = gb.req_ready; rv = gb.rsp_valid; rp = gb.rsp_p; ma = gb.mul_a; mb = gb.mul_b;
    end
    gk = model_grant(d);
    eg[d] = gk;
    chk($sformatf("ready%0d", d), int'(rdy), (gk < 0) ? 0 : (1 << gk));
    if (gk < 0) begin
      chk($sformatf("mul_a_idle%0d", d), int'(ma), 0);
      chk($sformatf("mul_b_idle%0d", d), int'(mb), 0);
    end
    have = 1'b0;
    if (reset) begin
      if (d == 0) qa.delete(); else qb.delete();
    end else if (d == 0) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin e = qa.pop_front(); have = 1'b1; end
    end else begin
      if (qb.size() > 0 && qb[0].due == cyc) begin e = qb.pop_front(); have = 1'b1; end
    end
    if (have) begin
      chk($sformatf("rsp_valid%0d", d), int'(rv), 1 << e.k);
      chk($sformatf("rsp_p%0d", d), int'(rp), int'(e.p));
    end else begin
      chk($sformatf("rsp_idle%0d", d), int'(rv), 0);
    end
    if (gk >= 0) begin
      e.due = cyc + LAT;
      e.k   = gk;
      e.p   = W'(opa[d][gk] * opb[d][gk]);
      if (d == 0) qa.push_back(e); else qb.push_back(e);
    end
    for (int k = 0; k < N; k++) begin
      if (!reset && vv[d][k] && gk != k) wait_c[d][k]++;
      else wait_c[d][k] = 0;
      if (wait_c[d][k] > max_wait[d]) max_wait[d] = wait_c[d][k];
    end
    if (reset) begin
      last_k[d] = -1; run[d] = 0; last_lock[d] = 1'b0; prev_gnt[d] = 1'b0;
    end else if (gk >= 0) begin
      if (prev_gnt[d] && last_lock[d] && last_k[d] == gk)
        run[d] = (run[d] < max_burst(d)) ? run[d] + 1 : run[d];
      else
        run[d] = 1;
      last_lock[d] = ll[d][gk];
      last_k[d]    = gk;
      prev_gnt[d]  = 1'b1;
    end else begin
      prev_gnt[d] = 1'b0;
      run[d]      = 0;
    end
  endtask

  task automatic settle_check();
    apply();
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic advance();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      vv[d] = '0; ll[d] = '0; last_k[d] = -1; run[d] = 0;
      last_lock[d] = 1'b0; prev_gnt[d] = 1'b0; eg[d] = -1; max_wait[d] = 0;
      for (int k = 0; k < N; k++) begin
        opa[d][k] = '0; opb[d][k] = '0; wait_c[d][k] = 0;
      end
    end
    apply();

    // rst  va    la    ea    ra    vb    lb    eb    rb
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0);
    add(0, 4'hF, 4'h0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0);
    add(0, 4'hF, 4'h0, 4'h4, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0);
    add(0, 4'hF, 4'h0, 4'h8, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2);
    add(0, 4'hF, 4'h0, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2);
    add(0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h3, 4'h2, 4'h1, 4'h2);
    add(0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h2);
    add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hA, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hA, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hA, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hA, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hA, 4'h2, 4'h8, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hB, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hA, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    @(negedge clk);
    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      vv[0] = tbl[i].va; ll[0] = tbl[i].la;
      vv[1] = tbl[i].vb; ll[1] = tbl[i].lb;
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < N; k++) begin
          opa[d][k] = W'($urandom_range(0, 65535));
          opb[d][k] = W'($urandom_range(0, 65535));
        end
      settle_check();
      chk($sformatf("tbl%0d_ready_a", i), int'(ga.req_ready), int'(tbl[i].ea));
      chk($sformatf("tbl%0d_rsp_a", i),   int'(ga.rsp_valid), int'(tbl[i].ra));
      chk($sformatf("tbl%0d_ready_b", i), int'(gb.req_ready), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_rsp_b", i),   int'(gb.rsp_valid), int'(tbl[i].rb));
      advance();
    end

    // Lone requester 2 with 3*5: product appears exactly LAT cycles later.
    reset = 1'b0;
    vv[0] = 4'b0100; ll[0] = '0; vv[1] = '0; ll[1] = '0;
    opa[0][2] = 16'd3; opb[0][2] = 16'd5;
    settle_check();
    chk("lone_ready", int'(ga.req_ready), 4);
    chk("lone_mul_a", int'(ga.mul_a), 3);
    advance();
    vv[0] = '0;
    repeat (LAT - 1) begin
      settle_check();
      chk("lone_wait", int'(ga.rsp_valid), 0);
      advance();
    end
    settle_check();
    chk("lone_rsp_valid", int'(ga.rsp_valid), 4);
    chk("lone_rsp_p", int'(ga.rsp_p), 15);
    advance();

    // Random stress: requesters hold their pair until granted.
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < N; k++) begin
          if (vv[d][k] && eg[d] == k) begin
            vv[d][k] = ($urandom_range(0, 1) == 1);
            opa[d][k] = W'($urandom_range(0, 65535));
            opb[d][k] = W'($urandom_range(0, 65535));
          end else if (!vv[d][k]) begin
            vv[d][k] = ($urandom_range(0, 3) == 0);
            opa[d][k] = W'($urandom_range(0, 65535));
            opb[d][k] = W'($urandom_range(0, 65535));
          end
          ll[d][k] = ($urandom_range(0, 1) == 1);
        end
      settle_check();
      advance();
    end
    vv[0] = '0; vv[1] = '0;
    repeat (LAT + 2) begin
      settle_check();
      advance();
    end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("fair_a", int'(max_wait[0] <= (N - 1) * 4 + 1), 1);
    chk("fair_b", int'(max_wait[1] <= (N - 1) * 2 + 1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one pipelined multiplier (2..16).
REQ-002 Parameter: MAX_BURST, default 8, maximum consecutive grants to one locked requester while others wait (1..255).
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: g  fixedp interface  --  supplies the number format (g.WIDTH) and multiplier latency (g.MUL_LAT >= 1).
REQ-006 Port: req_valid  input  NREQ  per-requester operand-pair valid.
REQ-007 Port: req_lock  input  NREQ  per-requester burst hold; meaningful only with req_valid.
REQ-008 Port: req_a, req_b  input  NREQ x g.WIDTH  per-requester operands.
REQ-009 Port: req_ready  output  NREQ  one-hot grant; the operand pair transfers when req_valid and req_ready are both high.
REQ-010 Port: mul_a, mul_b  output  g.WIDTH  operands to the shared multiplier.
REQ-011 Port: mul_p  input  g.WIDTH  multiplier product, valid g.MUL_LAT cycles after the operands.
REQ-012 Port: rsp_valid  output  NREQ  one-hot; marks the requester owning the product on rsp_p.
REQ-013 Port: rsp_p  output  g.WIDTH  product, equal to mul_p.

Function
REQ-014 At most one req_ready bit SHALL be high per cycle, and only for a requester whose req_valid is high; req_ready SHALL be combinational from req_valid and the registered state.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer ptr and wraps from NREQ-1 to 0; the first valid requester wins.
REQ-016 After a grant to k without a lock hold, ptr SHALL become (k+1) mod NREQ; with no grant, ptr SHALL hold.
REQ-017 Lock: if k is granted with req_lock[k]=1, k SHALL win the next cycle if req_valid[k]=1, regardless of ptr, while burst_cnt < MAX_BURST.
REQ-018 burst_cnt SHALL count consecutive grants to the same locked requester; it resets to 1 on a grant to a new requester and to 0 on an idle cycle.
REQ-019 When burst_cnt = MAX_BURST and another requester is valid, the lock SHALL be overridden: ptr moves to k+1 and normal round-robin applies; if no other requester is valid, k SHALL continue and burst_cnt saturates.
REQ-020 A locked requester dropping req_valid SHALL release the lock immediately, with no idle cycle inserted.
REQ-021 mul_a/mul_b SHALL equal the granted requester's operands in the grant cycle, and 0 when nothing is granted.
REQ-022 The one-hot grant SHALL be delayed exactly g.MUL_LAT cycles; rsp_valid = delayed grant, and rsp_p = mul_p whenever any rsp_valid bit is high.
REQ-023 Throughput SHALL be one grant per cycle with no bubbles between different requesters or between lock bursts.
REQ-024 Requesters not granted SHALL see req_ready=0; their operands SHALL be ignored, and they are required to hold them until granted.

Reset
REQ-025 While reset is high: ptr=0, burst_cnt=0, lock owner cleared, delay line cleared, req_ready=0, rsp_valid=0, mul_a=mul_b=0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight products: rsp_valid stays 0 for the g.MUL_LAT cycles after release unless new grants occur.

Structure
REQ-027 The requester-index type (clog2 of NREQ) and the round-robin first-one-from-pointer function SHALL reside in the shared matlib package.
REQ-028 The grant delay line SHALL be one sub-module: an instance of the existing valid delay block with WIDTH=NREQ and DELAY=g.MUL_LAT.

Verification
REQ-029 NREQ=4, MUL_LAT=3, all four valid continuously, no lock, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid shows the same sequence 3 cycles later.
REQ-030 Only requester 2 valid with a=3, b=5 (integer format) -> req_ready=0100 in cycle t; rsp_valid=0100 with rsp_p=15 in cycle t+3.
REQ-031 Requester 1 locked and valid, requester 3 valid, MAX_BURST=4 -> grants 1,1,1,1,3, then ptr=0.
REQ-032 Requester 1 locked alone, MAX_BURST=2 -> grants 1 every cycle; burst_cnt saturates at 2; requester 0 becomes valid -> granted on the next cycle.
REQ-033 Reset pulsed 1 cycle while 3 products are in flight -> no rsp_valid for 3 cycles after release; ptr=0 and the next grant goes to the lowest valid index.
REQ-034 Random valid/lock stress, 10k cycles -> each accepted pair produces exactly one rsp to the same requester, in grant order, with correct product; no requester waits more than (NREQ-1)*MAX_BURST+1 cycles once valid.
